// File: rtl/store_issue_ctrl_pkg.sv
// Shared opcode constants, instruction bundle and store FSM state
// for the data-memory store path.
package store_issue_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] STORE_OP = 7'b0100011;
    localparam logic [6:0] LOAD_OP  = 7'b0000011;

    localparam logic [2:0] LS_BYTE = 3'b000;
    localparam logic [2:0] LS_HALF = 3'b001;
    localparam logic [2:0] LS_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } store_state_t;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] inst_addr;
    } inst_t;

endpackage

// File: rtl/store_lane_align.sv
// Maps a store's size and byte address onto byte lanes;
// flags misaligned or unknown-size stores as illegal.
module store_lane_align
    import store_issue_ctrl_pkg::*;
#(
    parameter int word_width = 32,
    localparam int lane_count = word_width / 8
) (
    input  logic [2:0]            funct3,
    input  logic [word_width-1:0] alu_result,
    input  logic [word_width-1:0] store_data,
    output logic [lane_count-1:0] be,
    output logic [word_width-1:0] wdata,
    output logic [word_width-1:0] aligned_addr,
    output logic                  illegal
);

    localparam int lb = $clog2(lane_count);

    logic [lb-1:0] a;

    assign a = alu_result[lb-1:0];
    assign aligned_addr = {alu_result[word_width-1:lb], {lb{1'b0}}};

    always_comb begin
        be      = '0;
        wdata   = '0;
        illegal = 1'b0;
        unique case (1'b1)
            (funct3 == LS_BYTE): begin
                be    = lane_count'(1) << a;
                wdata = {lane_count{store_data[7:0]}};
            end
            (funct3 == LS_HALF): begin
                illegal = a[0];
                be      = lane_count'(3) << a;
                wdata   = {(lane_count / 2){store_data[15:0]}};
            end
            (funct3 == LS_WORD): begin
                illegal = (a != '0);
                be      = '1;
                wdata   = store_data;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_issue_ctrl.sv
// Store issue FSM: registers one aligned write, holds it until
// the memory acks, stalls upstream meanwhile, pulses done/fault.
module store_issue_ctrl
    import store_issue_ctrl_pkg::*;
#(
    parameter int word_width = 32,
    localparam int lane_count = word_width / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  inst_t                 curr_inst,
    input  logic                  inst_valid,
    input  logic [word_width-1:0] alu_result,
    input  logic                  alu_result_valid,
    input  logic [word_width-1:0] store_data,
    output logic                  mem_req,
    output logic [word_width-1:0] mem_addr,
    output logic [word_width-1:0] mem_wdata,
    output logic [lane_count-1:0] mem_be,
    input  logic                  mem_ack,
    output logic                  stall,
    output logic                  store_done,
    output logic                  store_fault
);

    store_state_t state, state_next;

    logic [lane_count-1:0] al_be;
    logic [word_width-1:0] al_wdata;
    logic [word_width-1:0] al_addr;
    logic                  al_illegal;
    logic                  present;
    logic                  accept_ok;
    logic                  unused_inst;

    assign unused_inst = ^{curr_inst.imm, curr_inst.inst_addr};

    store_lane_align #(
        .word_width(word_width)
    ) u_align (
        .funct3      (curr_inst.funct3),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .be          (al_be),
        .wdata       (al_wdata),
        .aligned_addr(al_addr),
        .illegal     (al_illegal)
    );

    // DONE counts as idle for accepting the next store
    assign present = (state != REQ) && inst_valid
                  && alu_result_valid
                  && (curr_inst.opcode == STORE_OP);
    assign accept_ok = present && !al_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept_ok) state_next = REQ;
            REQ:     if (mem_ack)   state_next = DONE;
            DONE:    state_next = accept_ok ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req    = (state == REQ);
        stall      = (state == REQ);
        store_done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            store_fault <= 1'b0;
        end else begin
            store_fault <= present && al_illegal;
            if (accept_ok) begin
                mem_addr  <= al_addr;
                mem_wdata <= al_wdata;
                mem_be    <= al_be;
            end
        end
    end

endmodule

// File: tb/tb_store_issue_ctrl.sv
// Directed bench for store_issue_ctrl: vector table of single
// stores plus hand sequences for wait, back-to-back and reset.
module tb_store_issue_ctrl;
    import store_issue_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    inst_t       curr_inst;
    logic        inst_valid;
    logic [31:0] alu_result;
    logic        alu_result_valid;
    logic [31:0] store_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        stall;
    logic        store_done;
    logic        store_fault;

    int checks = 0;
    int errors = 0;

    store_issue_ctrl #(.word_width(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .curr_inst       (curr_inst),
        .inst_valid      (inst_valid),
        .alu_result      (alu_result),
        .alu_result_valid(alu_result_valid),
        .store_data      (store_data),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .mem_ack         (mem_ack),
        .stall           (stall),
        .store_done      (store_done),
        .store_fault     (store_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] maddr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic present(input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] addr,
                           input logic [31:0] data);
        curr_inst        = '0;
        curr_inst.opcode = op;
        curr_inst.funct3 = f3;
        inst_valid       = 1'b1;
        alu_result       = addr;
        alu_result_valid = 1'b1;
        store_data       = data;
    endtask

    task automatic idle_in();
        curr_inst        = '0;
        inst_valid       = 1'b0;
        alu_result       = '0;
        alu_result_valid = 1'b0;
        store_data       = '0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, ".req"},   {31'b0, mem_req},     32'h0);
        chk({name, ".stall"}, {31'b0, stall},       32'h0);
        chk({name, ".done"},  {31'b0, store_done},  32'h0);
        chk({name, ".fault"}, {31'b0, store_fault}, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{LS_BYTE, 32'h1000, 32'hAABBCCDD, 1'b0, 4'b0001, 32'hDDDDDDDD, 32'h1000};
        vecs[1]  = '{LS_BYTE, 32'h1001, 32'hAABBCCDD, 1'b0, 4'b0010, 32'hDDDDDDDD, 32'h1000};
        vecs[2]  = '{LS_BYTE, 32'h1002, 32'h000000A5, 1'b0, 4'b0100, 32'hA5A5A5A5, 32'h1000};
        vecs[3]  = '{LS_BYTE, 32'h1003, 32'hAABBCCDD, 1'b0, 4'b1000, 32'hDDDDDDDD, 32'h1000};
        vecs[4]  = '{LS_HALF, 32'h2002, 32'h12345678, 1'b0, 4'b1100, 32'h56785678, 32'h2000};
        vecs[5]  = '{LS_HALF, 32'h2000, 32'h0000BEEF, 1'b0, 4'b0011, 32'hBEEFBEEF, 32'h2000};
        vecs[6]  = '{LS_HALF, 32'h2001, 32'h12345678, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[7]  = '{LS_WORD, 32'h3004, 32'hCAFEF00D, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h3004};
        vecs[8]  = '{LS_WORD, 32'h3001, 32'hCAFEF00D, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[9]  = '{LS_WORD, 32'h3002, 32'hCAFEF00D, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[10] = '{3'b011,  32'h3000, 32'hCAFEF00D, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[11] = '{3'b100,  32'h3000, 32'hCAFEF00D, 1'b1, 4'b0000, 32'h0,        32'h0};

        rst_n   = 1'b0;
        mem_ack = 1'b0;
        idle_in();
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset.addr",  mem_addr,  32'h0);
        chk("reset.wdata", mem_wdata, 32'h0);
        chk("reset.be",    {28'b0, mem_be}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // table: single stores, ack on first REQ cycle
        for (int i = 0; i < 12; i++) begin
            present(STORE_OP, vecs[i].f3, vecs[i].addr, vecs[i].data);
            @(negedge clk);
            idle_in();
            if (vecs[i].fault) begin
                chk($sformatf("v%0d.fault", i), {31'b0, store_fault}, 32'h1);
                chk($sformatf("v%0d.req", i),   {31'b0, mem_req},     32'h0);
                chk($sformatf("v%0d.stall", i), {31'b0, stall},       32'h0);
                @(negedge clk);
                chk($sformatf("v%0d.fault1", i), {31'b0, store_fault}, 32'h0);
                chk($sformatf("v%0d.req1", i),   {31'b0, mem_req},     32'h0);
            end else begin
                chk($sformatf("v%0d.req", i),   {31'b0, mem_req}, 32'h1);
                chk($sformatf("v%0d.stall", i), {31'b0, stall},   32'h1);
                chk($sformatf("v%0d.addr", i),  mem_addr,  vecs[i].maddr);
                chk($sformatf("v%0d.wdata", i), mem_wdata, vecs[i].wdata);
                chk($sformatf("v%0d.be", i), {28'b0, mem_be}, {28'b0, vecs[i].be});
                chk($sformatf("v%0d.nofault", i), {31'b0, store_fault}, 32'h0);
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
                chk($sformatf("v%0d.done", i),  {31'b0, store_done}, 32'h1);
                chk($sformatf("v%0d.req0", i),  {31'b0, mem_req},    32'h0);
                chk($sformatf("v%0d.stall0", i), {31'b0, stall},     32'h0);
                @(negedge clk);
                chk($sformatf("v%0d.done0", i), {31'b0, store_done}, 32'h0);
            end
        end

        // long ack wait: request and payload held for 3 cycles
        present(STORE_OP, LS_BYTE, 32'h1003, 32'hAABBCCDD);
        @(negedge clk);
        idle_in();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("wait%0d.req", k), {31'b0, mem_req}, 32'h1);
            chk($sformatf("wait%0d.addr", k), mem_addr, 32'h1000);
            chk($sformatf("wait%0d.wdata", k), mem_wdata, 32'hDDDDDDDD);
            chk($sformatf("wait%0d.be", k), {28'b0, mem_be}, 32'h8);
            chk($sformatf("wait%0d.done", k), {31'b0, store_done}, 32'h0);
            @(negedge clk);
        end
        chk("wait3.req", {31'b0, mem_req}, 32'h1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("wait.done", {31'b0, store_done}, 32'h1);
        chk("wait.req0", {31'b0, mem_req},    32'h0);
        @(negedge clk);

        // back-to-back: second store waits through REQ, taken in DONE
        present(STORE_OP, LS_WORD, 32'h40, 32'h11111111);
        @(negedge clk);
        chk("b2b.req1",  {31'b0, mem_req}, 32'h1);
        chk("b2b.addr1", mem_addr, 32'h40);
        present(STORE_OP, LS_WORD, 32'h44, 32'h22222222);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b.done1", {31'b0, store_done}, 32'h1);
        chk("b2b.gap",   {31'b0, mem_req},    32'h0);
        chk("b2b.hold",  mem_addr, 32'h40);
        @(negedge clk);
        idle_in();
        chk("b2b.req2",   {31'b0, mem_req}, 32'h1);
        chk("b2b.addr2",  mem_addr,  32'h44);
        chk("b2b.wdata2", mem_wdata, 32'h22222222);
        chk("b2b.done0",  {31'b0, store_done}, 32'h0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b.done2", {31'b0, store_done}, 32'h1);
        @(negedge clk);

        // asynchronous reset while in REQ
        present(STORE_OP, LS_WORD, 32'h5000, 32'h5A5A5A5A);
        @(negedge clk);
        idle_in();
        chk("rst.pre_req", {31'b0, mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_quiet("rst.async");
        chk("rst.addr",  mem_addr,  32'h0);
        chk("rst.wdata", mem_wdata, 32'h0);
        chk("rst.be",    {28'b0, mem_be}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("rst.after");
        present(STORE_OP, LS_HALF, 32'h6002, 32'h0000ABCD);
        @(negedge clk);
        idle_in();
        chk("rst.new_req", {31'b0, mem_req}, 32'h1);
        chk("rst.new_be",  {28'b0, mem_be}, 32'hC);
        chk("rst.new_wd",  mem_wdata, 32'hABCDABCD);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rst.new_done", {31'b0, store_done}, 32'h1);
        @(negedge clk);

        // ignored inputs: load, invalid store, spurious ack
        present(LOAD_OP, LS_WORD, 32'h7000, 32'h1);
        mem_ack = 1'b1;
        @(negedge clk);
        chk_quiet("ign.load");
        present(STORE_OP, LS_WORD, 32'h7000, 32'h1);
        inst_valid = 1'b0;
        @(negedge clk);
        chk_quiet("ign.invalid");
        inst_valid       = 1'b1;
        alu_result_valid = 1'b0;
        @(negedge clk);
        chk_quiet("ign.addr_invalid");
        idle_in();
        mem_ack = 1'b0;
        @(negedge clk);
        chk_quiet("ign.after");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
